// File: rtl/cam_pattern_tx.sv
// Synthetic OV7670-style DVP source: emits RGB565 test patterns as a byte stream
// (vsync/href/data), two bytes per pixel, high byte first, one byte per clk.
module cam_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int CHECK_LOG2  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] const_pixel,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int L         = 2 * H_ACTIVE + H_BLANK;
    localparam int HW        = $clog2(L);
    localparam int MAX_VA_VF = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_VS_VB = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_LINES = (MAX_VA_VF > MAX_VS_VB) ? MAX_VA_VF : MAX_VS_VB;
    localparam int LW        = $clog2(MAX_LINES + 1);
    localparam int BAR_W     = H_ACTIVE / 8;
    localparam int BPW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t           state, n_state;
    logic [HW-1:0]    hcnt, n_hcnt;
    logic [LW-1:0]    line_cnt, n_line;
    logic [2:0]       bar_idx, n_bar_idx;
    logic [BPW-1:0]   bar_px, n_bar_px;
    logic [1:0]       pat_q;
    logic [15:0]      const_q;

    logic             n_latch, n_href, n_done;
    logic [7:0]       n_data;
    logic [15:0]      pixel;
    logic [7:0]       x, y;
    int               state_lines;

    // x/y are truncated views of the counters; only some bits feed a given pattern.
    logic unused_xy;
    assign unused_xy = ^{x, y};

    // The next position is computed here and every output is registered from it,
    // so the pins always describe the position held in state/hcnt/line_cnt.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        n_state     = state;
        n_hcnt      = hcnt;
        n_line      = line_cnt;
        n_bar_idx   = bar_idx;
        n_bar_px    = bar_px;
        n_latch     = 1'b0;
        pixel       = 16'h0000;
        state_lines = 1;

        case (state)
            VSYNC:   state_lines = VSYNC_LINES;
            VBACK:   state_lines = V_BACK;
            ACTIVE:  state_lines = V_ACTIVE;
            VFRONT:  state_lines = V_FRONT;
            default: state_lines = 1;
        endcase

        if (state == IDLE) begin
            if (enable) begin
                n_state = VSYNC;
                n_hcnt  = '0;
                n_line  = '0;
                n_latch = 1'b1;
            end
        end else if (hcnt == HW'(L - 1)) begin
            n_hcnt = '0;
            if (line_cnt == LW'(state_lines - 1)) begin
                n_line = '0;
                case (state)
                    VSYNC:   n_state = VBACK;
                    VBACK:   n_state = ACTIVE;
                    ACTIVE:  n_state = VFRONT;
                    default: begin
                        n_state = enable ? VSYNC : IDLE;
                        n_latch = enable;
                    end
                endcase
            end else begin
                n_line = line_cnt + 1'b1;
            end
        end else begin
            n_hcnt = hcnt + 1'b1;
        end

        // Bar counter advances once per pixel (on each even byte) instead of dividing x.
        if (n_hcnt == '0) begin
            n_bar_idx = '0;
            n_bar_px  = '0;
        end else if (!n_hcnt[0]) begin
            if (bar_px == BPW'(BAR_W - 1)) begin
                n_bar_px  = '0;
                n_bar_idx = bar_idx + 3'd1;
            end else begin
                n_bar_px  = bar_px + 1'b1;
            end
        end

        x = 8'(n_hcnt >> 1);
        y = 8'(n_line);

        case (pat_q)
            2'd0: begin
                case (n_bar_idx)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = {x[7:3], x[7:2], x[7:3]};
            2'd2:    pixel = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
            default: pixel = const_q;
        endcase

        n_href = (n_state == ACTIVE) && (int'(n_hcnt) < 2 * H_ACTIVE);
        n_data = n_href ? (n_hcnt[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
        n_done = (n_state == VFRONT) && (n_line == LW'(V_FRONT - 1)) &&
                 (n_hcnt == HW'(L - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the frame-latched pattern registers are reset too, so a reset leaves no stale frame state.
            state       <= IDLE;
            hcnt        <= '0;
            line_cnt    <= '0;
            bar_idx     <= '0;
            bar_px      <= '0;
            pat_q       <= '0;
            const_q     <= '0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= n_state;
            hcnt        <= n_hcnt;
            line_cnt    <= n_line;
            bar_idx     <= n_bar_idx;
            bar_px      <= n_bar_px;
            if (n_latch) begin
                pat_q   <= pattern_sel;
                const_q <= const_pixel;
            end
            cam_vsync   <= (n_state == VSYNC);
            cam_href    <= n_href;
            cam_data    <= n_data;
            frame_start <= n_latch;
            frame_done  <= n_done;
            if (n_done) frame_count <= frame_count + 16'd1;
            busy        <= (n_state != IDLE);
        end
    end

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Self-checking bench for cam_pattern_tx: frame-offset reference model checked every
// cycle, plus directed byte tables, frame metrics, enable drop and mid-frame reset.
module tb_cam_pattern_tx;

    localparam int HA = 8, HB = 4, VS = 1, VB = 1, VA = 2, VF = 1, CL = 0;
    localparam int L  = 2 * HA + HB;
    localparam int F  = L * (VS + VB + VA + VF);

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [1:0]  pattern_sel;
    logic [15:0] const_pixel;
    logic        cam_vsync, cam_href, frame_start, frame_done, busy;
    logic [7:0]  cam_data;
    logic [15:0] frame_count;

    cam_pattern_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS),
        .V_BACK(VB), .V_FRONT(VF), .CHECK_LOG2(CL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .const_pixel(const_pixel), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .frame_start(frame_start), .frame_done(frame_done),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position is a cycle offset within the frame.
    logic [15:0] bar_colours [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                     16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic        m_run;
    int          m_t;
    logic [15:0] m_cnt, m_const;
    logic [1:0]  m_pat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_t <= 0; m_cnt <= 16'h0; m_pat <= 2'd0; m_const <= 16'h0;
        end else if (!m_run) begin
            if (enable) begin
                m_run <= 1'b1; m_t <= 0; m_pat <= pattern_sel; m_const <= const_pixel;
            end
        end else if (m_t == F - 1) begin
            if (enable) begin
                m_t <= 0; m_pat <= pattern_sel; m_const <= const_pixel;
            end else begin
                m_run <= 1'b0;
            end
        end else begin
            m_t <= m_t + 1;
            if (m_t + 1 == F - 1) m_cnt <= m_cnt + 16'd1;
        end
    end

    function automatic logic [15:0] model_pixel(input int px, input int py);
        case (m_pat)
            2'd0:    return bar_colours[px / (HA / 8)];
            2'd1:    return 16'((((px >> 3) & 31) << 11) | (((px >> 2) & 63) << 5) | ((px >> 3) & 31));
            2'd2:    return ((((px >> CL) ^ (py >> CL)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: return m_const;
        endcase
    endfunction

    function automatic logic [28:0] exp_outputs();
        int line, h, ay;
        logic vs, act;
        logic [15:0] pix;
        logic [7:0] d;
        line = m_t / L;
        h    = m_t % L;
        ay   = line - VS - VB;
        vs   = m_run && (line < VS);
        act  = m_run && (ay >= 0) && (ay < VA) && (h < 2 * HA);
        d    = 8'h00;
        if (act) begin
            pix = model_pixel(h / 2, ay);
            d   = ((h % 2) == 1) ? pix[7:0] : pix[15:8];
        end
        return {vs, act, d, m_run && (m_t == 0), m_run && (m_t == F - 1), m_cnt, m_run};
    endfunction

    logic [28:0] dut_vec;
    assign dut_vec = {cam_vsync, cam_href, cam_data, frame_start, frame_done, frame_count, busy};

    logic cmp_en = 1'b0;
    always @(negedge clk)
        if (cmp_en && !rst) check("outputs_vs_model", 32'(dut_vec), 32'(exp_outputs()));

    // Per-frame metrics: vsync/href cycle counts and done-to-done period.
    logic mon_en = 1'b0;
    int   vs_n = 0, hr_n = 0, cyc = 0, prev_done = 0;
    bit   have_prev = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (cam_vsync) vs_n++;
            if (cam_href)  hr_n++;
            if (frame_done) begin
                check("vsync_cycles", 32'(vs_n), 32'(VS * L));
                check("href_cycles", 32'(hr_n), 32'(VA * 2 * HA));
                if (have_prev) check("frame_period", 32'(cyc - prev_done), 32'(F));
                prev_done = cyc; have_prev = 1'b1; vs_n = 0; hr_n = 0;
            end
            cyc++;
        end
    end

    task automatic wait_href_new();
        int n = 0;
        while (cam_href === 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (cam_href !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("href_seen", 32'(cam_href), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        if (frame_done === 1'b1) @(negedge clk);
        while (frame_done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    logic [7:0] bar_line [20] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] chk_line0 [16] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF,
                                   8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] chk_line1 [16] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00,
                                   8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; const_pixel = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(dut_vec), 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        // Colour bars, continuous frames with enable held high.
        enable = 1'b1; mon_en = 1'b1;
        wait_href_new();
        for (int i = 0; i < 20; i++) begin
            check("bar_byte", 32'(cam_data), 32'(bar_line[i]));
            @(negedge clk);
        end
        for (int k = 1; k <= 3; k++) begin
            wait_done();
            check("frame_count_run", 32'(frame_count), 32'(k));
        end

        // Constant pattern frozen for the whole frame despite a mid-frame change.
        pattern_sel = 2'd3; const_pixel = 16'hA55A;
        wait_href_new();
        check("const_hi_l0", 32'(cam_data), 32'h0A5);
        @(negedge clk);
        check("const_lo_l0", 32'(cam_data), 32'h05A);
        const_pixel = 16'h1234;
        wait_href_new();
        check("const_hi_l1", 32'(cam_data), 32'h0A5);
        @(negedge clk);
        check("const_lo_l1", 32'(cam_data), 32'h05A);
        wait_done();
        wait_href_new();
        check("const_next_hi", 32'(cam_data), 32'h012);
        @(negedge clk);
        check("const_next_lo", 32'(cam_data), 32'h034);
        pattern_sel = 2'd2;
        wait_done();
        check("frame_count_5", 32'(frame_count), 32'd5);

        // Checkerboard with 1-pixel squares.
        wait_href_new();
        for (int i = 0; i < 16; i++) begin
            check("checker_l0", 32'(cam_data), 32'(chk_line0[i]));
            @(negedge clk);
        end
        wait_href_new();
        for (int i = 0; i < 16; i++) begin
            check("checker_l1", 32'(cam_data), 32'(chk_line1[i]));
            @(negedge clk);
        end

        // Drop enable mid-frame: the frame still completes, then the block idles.
        enable = 1'b0;
        wait_done();
        check("drop_count", 32'(frame_count), 32'd6);
        check("drop_busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("drop_busy_after", 32'(busy), 32'd0);
        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("idle_pins", 32'({cam_vsync, cam_href, cam_data, frame_start, busy}), 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset while href is high.
        enable = 1'b1; pattern_sel = 2'd0;
        wait_href_new();
        cmp_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_pins", 32'({cam_vsync, cam_href, cam_data, busy}), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        @(negedge clk);
        pattern_sel = 2'd1;
        rst = 1'b0;
        check("post_rst_vsync_low", 32'(cam_vsync), 32'd0);
        cmp_en = 1'b1;
        @(negedge clk);
        check("post_rst_vsync", 32'(cam_vsync), 32'd1);
        check("post_rst_start", 32'(frame_start), 32'd1);
        wait_done();
        check("post_rst_count", 32'(frame_count), 32'd1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_pattern_tx.md
Name: cam_pattern_tx

Overview:
- Synthesizable OV7670-style DVP transmitter that emits a camera byte stream: cam_vsync, cam_href and 8-bit data, RGB565, two bytes per pixel, high byte first.
- Drives the same pins the Camera receiver samples, so the capture path, buffer and VGA readout can be exercised in simulation and on the board without a sensor.
- clk stands in for cam_pclk; one byte is produced per clk cycle.

Parameters:
H_ACTIVE, 640, active pixels per line; must be a multiple of 8
V_ACTIVE, 480, active lines per frame
H_BLANK, 144, clk cycles per line with href low (after the active bytes)
VSYNC_LINES, 3, line periods with vsync high
V_BACK, 17, blank line periods between vsync and the first active line
V_FRONT, 10, blank line periods after the last active line
CHECK_LOG2, 3, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
clk  in  1  byte clock (pclk role)
rst  in  1  asynchronous reset, active-high
enable  in  1  run request, sampled in IDLE and at the end of each frame
pattern_sel  in  2  0 colour bars, 1 grey ramp, 2 checkerboard, 3 constant
const_pixel  in  16  RGB565 value used for pattern 3
cam_vsync  out  1  frame sync, active-high
cam_href  out  1  line valid, active-high
cam_data  out  8  pixel byte
frame_start  out  1  one-cycle pulse on the first vsync-high cycle
frame_done  out  1  one-cycle pulse on the last cycle of V_FRONT
frame_count  out  16  completed frames; wraps FFFF->0000
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0 and state IDLE. Asynchronous reset aborts any frame immediately; there is no partial-frame completion.
- Line period L = 2*H_ACTIVE + H_BLANK clk cycles. hcnt runs 0..L-1 and wraps.
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Each non-IDLE state lasts an integer number of lines: VSYNC_LINES, V_BACK, V_ACTIVE and V_FRONT respectively. A line counter clears on every state change.
- IDLE: enable=1 sampled at edge N moves the block to VSYNC. cam_vsync=1 and frame_start=1 in cycle N+1. pattern_sel and const_pixel are latched at this edge and are frozen for the whole frame.
- VSYNC: cam_vsync=1, cam_href=0 and cam_data=0 for VSYNC_LINES*L cycles.
- VBACK and VFRONT: vsync, href and data are all 0.
- ACTIVE: cam_href=1 for hcnt 0..2*H_ACTIVE-1, then 0 for H_BLANK cycles. Pixel x = hcnt>>1 and line y = the active line index.
  - Even hcnt: cam_data = pixel[15:8]. Odd hcnt: cam_data = pixel[7:0].
  - cam_data = 0 whenever href=0.
- End of VFRONT: frame_done pulses and frame_count increments on the same cycle.
  - enable=1 at that edge: go straight to VSYNC, with no idle gap.
  - enable=0 at that edge: go to IDLE.
  - Deasserting enable mid-frame has no effect until the frame ends.
- All outputs are registered and change only on the rising edge of clk. href and vsync never toggle in the middle of a byte pair.
- Patterns:
  - Colour bars: bar = x/(H_ACTIVE/8), tracked with a bar counter, no divider. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Grey ramp: {x[7:3], x[7:2], x[7:3]}.
  - Checkerboard: (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? FFFF : 0000.
  - Constant: the latched const_pixel.
- Counter widths: hcnt is sized for L, and line counters are sized for the largest line parameter. There is no overflow at the default parameters.

Test Plan:
- Params H_ACTIVE=8, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1 (L=20, frame=100 cycles). Enable held at 1 -> vsync high for 20 cycles, href high for 16 cycles in each of 2 active lines, frame_done every 100 cycles, back-to-back frames with no gap, frame_count 1,2,3.
- Same params, pattern 0 -> each active line bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00, then 4 zero bytes.
- pattern 3, const_pixel=A55A, with const_pixel changed to 1234 mid-frame -> every pixel of that frame reads A5 5A; the next frame reads 12 34.
- CHECK_LOG2=0, pattern 2 -> line 0 bytes 00 00 FF FF 00 00 FF FF …, line 1 inverted.
- Drop enable during ACTIVE -> the frame completes, frame_done pulses, busy falls the next cycle, and the outputs stay 0.
- Assert rst during ACTIVE with href=1 -> vsync, href, data and busy are 0 immediately. frame_count is 0. After release with enable=1, the first vsync appears one cycle later.
